// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int PC_STEP = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_entry_t;

    // Counters must hold the value DEPTH itself, not just DEPTH-1.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO with flush, registered storage,
// power-of-two depth so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 2,
    parameter int  CW      = cnt_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, response buffer, redirects.
// Optional FETCH_PERF_EN enables the decode-starvation counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DATA_WIDTH = DATA_W,
    parameter int                    FIFO_DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [31:0]           perf_stall_cnt
);
    localparam int CW = cnt_width(FIFO_DEPTH);

    typedef logic [ADDR_WIDTH-1:0] pc_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        pc_t                   pc;
    } entry_t;

    pc_t           pc;
    pc_t           tag_pc;
    pc_t           redir_tgt;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fire;
    logic          push;
    logic          pop;
    entry_t        head;
    entry_t        wentry;

    assign redir_tgt = redirect_pc & ~pc_t'(3);

    // Outstanding requests plus buffered words never exceed the buffer size,
    // so every response that is kept always has a slot waiting for it.
    assign imem_req  = !rst && !redirect_valid
                       && ((inflight + fifo_count) < CW'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;

    assign push        = imem_rvalid && (discard == '0) && !redirect_valid;
    assign instr_valid = !fifo_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign wentry      = '{instr: imem_rdata, pc: tag_pc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            tag_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect_valid) begin
            pc       <= redir_tgt;
            tag_pc   <= redir_tgt;
            inflight <= inflight - CW'(imem_rvalid);
            // Every request still outstanding belongs to the old path; the
            // inflight count already includes any pending discards.
            discard  <= inflight - CW'(imem_rvalid);
        end else begin
            if (fire) pc <= pc + ADDR_WIDTH'(PC_STEP);
            if (push) tag_pc <= tag_pc + ADDR_WIDTH'(PC_STEP);
            inflight <= inflight + CW'(fire) - CW'(imem_rvalid);
            if (imem_rvalid && (discard != '0)) discard <= discard - 1'b1;
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH),
        .CW      (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (instr_ready && !instr_valid && !redirect_valid
                     && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a behavioural memory and
// program-order reference model, plus directed latency/redirect/wrap checks.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [31:0] perf_stall_cnt;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          pops = 0;
    logic [15:0] pending[$];   // addresses accepted by memory, in order
    logic [47:0] exp_q[$];     // expected {instr, pc} in program order
    logic [15:0] model_pc = '0;
    logic [15:0] fetch_pc = '0;
    logic [47:0] e;
    longint      perf_model = 0;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor / scoreboard: observes settled handshakes before each rising edge.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            pending.delete();
            exp_q.delete();
            model_pc   = '0;
            fetch_pc   = '0;
            perf_model = 0;
        end else begin
            if (instr_ready && !instr_valid && !redirect_valid && perf_model < 64'hFFFF_FFFF)
                perf_model++;
            if (redirect_valid) check("redir_gate", {imem_req, instr_valid}, 2'b00);
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    exp_q.push_back({mem_word(model_pc), model_pc});
                    model_pc += 16'd4;
                end
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e[15:0]);
                check("instr", instr, e[47:16]);
                pops++;
            end
            if (imem_req && imem_gnt) begin
                check("imem_addr", imem_addr, fetch_pc);
                pending.push_back(imem_addr);
                fetch_pc += 16'd4;
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = {redirect_pc[15:2], 2'b00};
                fetch_pc = model_pc;
            end
        end
    end

    task automatic step(input bit g, input bit rdy, input bit allow_rv,
                        input bit redir, input logic [15:0] tgt);
        @(negedge clk);
        imem_gnt       = g;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (allow_rv && pending.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pending.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 1'b0);
        check("mid_rst_valid", instr_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_addr", imem_addr, 16'h0000);
    endtask

    initial begin
        int grants;
        bit seen;
        logic [31:0] perf_exp;

        // Reset state and release
        @(negedge clk); #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 16'h0);
        check("rst_perf", perf_stall_cnt, 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        check("rel_req", imem_req, 1'b1);
        check("rel_addr0", imem_addr, 16'h0000);

        // Latency: grant at cycle 0, response at 1, visible at 2
        step(1, 1, 1, 0, 0); check("lat_c0", instr_valid, 1'b0);
        step(1, 1, 1, 0, 0); check("lat_c1", instr_valid, 1'b0);
        step(1, 1, 1, 0, 0); check("lat_c2", {instr_valid, instr_pc}, {1'b1, 16'h0000});
        check("lat_c2_data", instr, mem_word(16'h0000));
        step(1, 1, 1, 0, 0); check("lat_c3", {instr_valid, instr_pc}, {1'b1, 16'h0004});
        repeat (6) step(1, 1, 1, 0, 0);

        // Back-pressure: buffer depth caps grants
        do_reset();
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 0, 0);
            if (imem_req && imem_gnt) grants++;
        end
        check("bp_grants", grants, 2);
        check("bp_req_low", imem_req, 1'b0);
        check("bp_valid", instr_valid, 1'b1);
        repeat (8) step(1, 1, 1, 0, 0);

        // Redirect with two requests in flight
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 16'h0100);
        check("redir_req", imem_req, 1'b0);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step(1, 1, 1, 0, 0);
            if (instr_valid) begin
                seen = 1;
                check("redir_first_pc", instr_pc, 16'h0100);
            end
        end
        if (!seen) check("redir_timeout", 1'b0, 1'b1);

        // Wrap and misaligned target
        do_reset();
        step(1, 1, 1, 1, 16'hFFFC);
        step(1, 1, 1, 0, 0);
        check("wrap_a", {imem_req, imem_addr}, {1'b1, 16'hFFFC});
        step(1, 1, 1, 0, 0);
        check("wrap_b", {imem_req, imem_addr}, {1'b1, 16'h0000});
        step(1, 1, 1, 1, 16'h0102);
        step(0, 1, 1, 0, 0);
        check("align_addr", imem_addr, 16'h0100);
        repeat (8) step(1, 1, 1, 0, 0);

        // Starvation counter
        do_reset();
        repeat (5) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        perf_exp = 32'd5;
`else
        perf_exp = 32'd0;
`endif
        check("perf_5", perf_stall_cnt, perf_exp);

        // Randomized traffic
        do_reset();
        pops = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0,
                     ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                                 : 16'($urandom));
            end
        end
        step(0, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        perf_exp = perf_model[31:0];
`else
        perf_exp = 32'd0;
`endif
        check("perf_rand", perf_stall_cnt, perf_exp);
        check("activity", pops > 200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
